// File: rtl/edge_det_pkg.sv
// Shared constants for the edge detector bank: default geometry and the
// reset value of the sticky flags.
package edge_det_pkg;

    localparam int   DEF_CHANNELS    = 8;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   DEF_FILTER_W    = 4;

    localparam logic FLAG_RST_VAL    = 1'b0;

endpackage : edge_det_pkg

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser chain, glitch filter with
// programmable length, rise/fall event select, one-cycle pulse and W1C flag.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_W    = DEF_FILTER_W
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                i_ena,
    input  logic                i_data,
    input  logic                i_rise_en,
    input  logic                i_fall_en,
    input  logic [FILTER_W-1:0] i_filt_len,
    input  logic                i_clr,
    output logic                o_pulse,
    output logic                o_flag
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [FILTER_W-1:0]    r_cnt;
    logic                   r_pulse;
    logic                   r_flag;

    logic                   w_s;
    logic                   w_diff;
    logic                   w_update;
    logic                   w_ev;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_diff   = (w_s != r_filt);
    // >= rather than == so a filt_len reduced mid-count still accepts.
    assign w_update = i_ena & w_diff & (r_cnt >= i_filt_len);
    assign w_ev     = w_update & ((w_s & i_rise_en) | (~w_s & i_fall_en));

    // Synchroniser runs regardless of ena so the level is current on resume.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_data};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (i_ena) begin
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_filt <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + FILTER_W'(1);
            end
        end
    end

    // A new event outranks a simultaneous clear so no edge is ever lost.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pulse <= 1'b0;
            r_flag  <= FLAG_RST_VAL;
        end else begin
            r_pulse <= w_ev;
            r_flag  <= (r_flag & ~i_clr) | w_ev;
        end
    end

    assign o_pulse = r_pulse;
    assign o_flag  = r_flag;

endmodule : edge_det_chan

// File: rtl/edge_detector_bank.sv
// Bank of independent edge-detector channels with a masked, registered-source
// interrupt line for the register front end.
module edge_detector_bank
    import edge_det_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_W    = DEF_FILTER_W
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                ena,
    input  logic [CHANNELS-1:0] data,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [FILTER_W-1:0] filt_len,
    input  logic [CHANNELS-1:0] clr,
    input  logic [CHANNELS-1:0] irq_mask,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] flags,
    output logic                irq
);

    logic [CHANNELS-1:0] w_masked;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W)
        ) u_chan (
            .clk        (clk),
            .rstb       (rstb),
            .i_ena      (ena),
            .i_data     (data[g]),
            .i_rise_en  (rise_en[g]),
            .i_fall_en  (fall_en[g]),
            .i_filt_len (filt_len),
            .i_clr      (clr[g]),
            .o_pulse    (pulse[g]),
            .o_flag     (flags[g])
        );
    end

    // Built only from flops and the static mask, so data glitches never reach irq.
    assign w_masked = flags & irq_mask;
    assign irq      = |w_masked;

endmodule : edge_detector_bank

// File: tb/tb_edge_detector_bank.sv
// Bench for edge_detector_bank: directed scenarios plus random traffic, with a
// per-cycle reference model feeding an expected-output queue.
module tb_edge_detector_bank;

    localparam int C     = 8;
    localparam int SS    = 2;
    localparam int FW    = 4;
    localparam int OBS_W = 2 * C + 1;

    logic          clk = 1'b0;
    logic          rstb;
    logic          ena;
    logic [C-1:0]  data;
    logic [C-1:0]  rise_en;
    logic [C-1:0]  fall_en;
    logic [FW-1:0] filt_len;
    logic [C-1:0]  clr;
    logic [C-1:0]  irq_mask;
    logic [C-1:0]  pulse;
    logic [C-1:0]  flags;
    logic          irq;

    int checks = 0;
    int errors = 0;

    logic [OBS_W-1:0] exp_q[$];
    logic             model_started = 1'b0;

    // Reference model state: accepted level, run of differing samples, input delay line.
    logic [C-1:0] m_level;
    logic [C-1:0] m_flags;
    int           m_run[C];
    logic [C-1:0] m_dly[$];

    edge_detector_bank #(
        .CHANNELS    (C),
        .SYNC_STAGES (SS),
        .FILTER_W    (FW)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .data     (data),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .filt_len (filt_len),
        .clr      (clr),
        .irq_mask (irq_mask),
        .pulse    (pulse),
        .flags    (flags),
        .irq      (irq)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_level = '0;
        m_flags = '0;
        for (int ch = 0; ch < C; ch++) m_run[ch] = 0;
        m_dly.delete();
        for (int i = 0; i < SS; i++) m_dly.push_back('0);
    endtask

    always @(posedge clk) begin : model_p
        logic [C-1:0] s;
        logic [C-1:0] ev;
        ev = '0;
        if (!rstb) begin
            model_reset();
        end else begin
            // The input seen by the filter is the one presented SS edges ago.
            s = m_dly.pop_front();
            m_dly.push_back(data);
            if (ena) begin
                for (int ch = 0; ch < C; ch++) begin
                    if (s[ch] == m_level[ch]) begin
                        m_run[ch] = 0;
                    end else begin
                        m_run[ch] = m_run[ch] + 1;
                        if (m_run[ch] >= int'(filt_len) + 1) begin
                            m_level[ch] = s[ch];
                            m_run[ch]   = 0;
                            if (s[ch] ? rise_en[ch] : fall_en[ch]) ev[ch] = 1'b1;
                        end
                    end
                end
            end
            m_flags = (m_flags & ~clr) | ev;
        end
        exp_q.push_back({ev, m_flags, |(m_flags & irq_mask)});
        model_started = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor_p
        logic [OBS_W-1:0] exp_v;
        logic [OBS_W-1:0] got_v;
        if (model_started) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {pulse, flags, irq};
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb_cycle @%0t: got pulse=%b flags=%b irq=%b, expected pulse=%b flags=%b irq=%b",
                             $time, got_v[2*C:C+1], got_v[C:1], got_v[0],
                             exp_v[2*C:C+1], exp_v[C:1], exp_v[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called just before edge 1 of a transition: reports the edge index of the
    // first pulse on ch (-1 if none within the budget) and the pulse count.
    task automatic measure_latency(input int ch, output int lat, output int n);
        lat = -1;
        n   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (pulse[ch]) begin
                if (lat < 0) lat = i;
                n++;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int lat;
        int n;
        rstb     = 1'b0;
        ena      = 1'b1;
        data     = '0;
        rise_en  = '0;
        fall_en  = '0;
        filt_len = FW'(3);
        clr      = '0;
        irq_mask = '0;
        repeat (3) tick();
        check("reset_pulse", 32'(pulse), 32'h0);
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_irq",   32'(irq),   32'h0);
        rstb = 1'b1;
        tick();

        // Basic rise on ch0 with L=3: pulse after edge SS+L+1 = 6.
        rise_en  = '1;
        irq_mask = 8'h01;
        data[0]  = 1'b1;
        measure_latency(0, lat, n);
        check("basic_rise_latency", 32'(lat), 32'd6);
        check("basic_rise_count",   32'(n),   32'd1);
        check("basic_rise_flag",    32'(flags[0]), 32'h1);
        check("basic_rise_irq",     32'(irq),      32'h1);
        tick();

        // Glitch reject on ch1: 3 samples high rejected, 4 accepted.
        data[1] = 1'b1;
        repeat (3) tick();
        data[1] = 1'b0;
        repeat (10) tick();
        check("glitch_reject_flag", 32'(flags[1]), 32'h0);
        data[1] = 1'b1;
        repeat (4) tick();
        data[1] = 1'b0;
        repeat (10) tick();
        check("glitch_accept_flag", 32'(flags[1]), 32'h1);

        // Mode select on ch5 with L=0.
        filt_len   = FW'(0);
        rise_en[5] = 1'b0;
        fall_en[5] = 1'b1;
        tick();
        data[5] = 1'b1;
        repeat (3) tick();
        data[5] = 1'b0;
        repeat (6) tick();
        clr = 8'h20;
        tick();
        clr = '0;
        rise_en[5] = 1'b1;
        data[5] = 1'b1;
        repeat (3) tick();
        data[5] = 1'b0;
        repeat (6) tick();

        // Clear collision on ch2 with L=3: event lands on edge 6.
        filt_len = FW'(3);
        irq_mask = 8'h04;
        tick();
        data[2] = 1'b1;
        repeat (5) tick();
        clr[2] = 1'b1;
        tick();
        check("collision_flag_set", 32'(flags[2]), 32'h1);
        tick();
        clr[2] = 1'b0;
        check("clear_flag", 32'(flags[2]), 32'h0);
        check("clear_irq",  32'(irq),      32'h0);

        // Enable freeze on ch3.
        irq_mask = '1;
        fall_en  = '1;
        ena      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data[3] = ~data[3];
            repeat (2) tick();
        end
        data[3] = 1'b1;
        repeat (8) tick();
        check("freeze_flag", 32'(flags[3]), 32'h0);
        ena = 1'b1;
        repeat (8) tick();
        check("resume_flag", 32'(flags[3]), 32'h1);

        // Async reset while ch4 is mid-count (cnt=2 after edge 4).
        data[4] = 1'b1;
        repeat (4) tick();
        rstb = 1'b0;
        #1;
        check("async_rst_flags", 32'(flags), 32'h0);
        check("async_rst_pulse", 32'(pulse), 32'h0);
        check("async_rst_irq",   32'(irq),   32'h0);
        repeat (2) tick();
        rstb = 1'b1;
        measure_latency(4, lat, n);
        check("post_rst_latency", 32'(lat), 32'd6);
        check("post_rst_count",   32'(n),   32'd1);
        tick();

        // Random traffic with slowly changing configuration.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 200 == 0) begin
                rise_en  = C'($urandom);
                fall_en  = C'($urandom);
                irq_mask = C'($urandom);
                filt_len = FW'($urandom_range(0, (1 << FW) - 1));
            end
            for (int ch = 0; ch < C; ch++) begin
                if ($urandom_range(0, 7) == 0) data[ch] = ~data[ch];
                clr[ch] = ($urandom_range(0, 15) == 0);
            end
            ena = ($urandom_range(0, 15) != 0);
            tick();
        end
        clr = '0;
        ena = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_edge_detector_bank
